ahb_sram_slave: RTL
===================

# ahb_sram_slave

AHB-Lite responder that terminates one crossbar slave port and serves a word-addressed internal register memory. It sits behind a bus slave port: it takes the granted master's `mas_send_type` payload plus `hsel`, and returns a `slv_send_type` payload (`hreadyout`, `hrdata`, `hresp`) that the crossbar routes back to the owning master. It supports configurable wait states, byte/halfword/word access with lane merging, and the two-cycle ERROR response.

## Interface
- `DEPTH`, 256: memory size in 32-bit words; power of two, 16..4096.
- `WAIT_STATES`, 0: hreadyout-low cycles inserted in every OKAY data phase; 0..15.
- `REGION_W`, 16: haddr bits decoded by the slave; the remaining upper bits are ignored, because the crossbar decoder has already qualified them.
- `hclk` input 1: bus clock, rising edge.
- `hreset` input 1: synchronous reset, active-high.
- `hsel` input 1: slave select from the crossbar arbiter.
- `slave_in` input `mas_send_type` (78): haddr[31:0], hwdata[31:0], htrans[1:0], hburst[2:0], hsize[2:0], hwrite, hprot[3:0], hmastlock.
- `slave_out` output `slv_send_type` (34): hreadyout, hrdata[31:0], hresp (0 = OKAY, 1 = ERROR).

## Operation
- htrans encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11. hburst, hprot and hmastlock are ignored, because every beat carries its own address.
- Address phase is accepted on a rising edge when all of the following hold:
  - hsel=1;
  - htrans is NONSEQ or SEQ;
  - hreadyout=1.
  - On acceptance, register addr_q, hsize_q, hwrite_q and err_q.
- IDLE or BUSY transfers, or hsel=0, are not accepted. The next cycle gives a zero-wait OKAY with hrdata=0.
- Word index = haddr[$clog2(DEPTH)+1:2]. Byte lane = haddr[1:0].
- Error condition (only when `AHB_SLV_ERR_EN` is defined). Any of:
  - hsize > 2;
  - misalignment: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]≠0;
  - out of range: haddr[REGION_W-1:0] ≥ DEPTH*4.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: hreadyout=1.
    - Accepted OKAY transfer → WAIT if WAIT_STATES>0, else LAST.
    - Accepted erroring transfer → ERR1.
  - WAIT: hreadyout=0 and a counter runs down from WAIT_STATES. When the counter reaches 1 → LAST.
  - LAST: hreadyout=1 and hresp=0.
    - Write: at the end of this cycle, merge hwdata into mem[addr_q] using byte enables from hsize_q and the lane.
    - Read: hrdata = mem[addr_q], full word, all lanes.
    - On the same edge a new transfer may be accepted (pipelined). Next state follows the IDLE rules.
  - ERR1: hreadyout=0, hresp=1. Next state is always ERR2. No address is sampled.
  - ERR2: hreadyout=1, hresp=1. A new transfer may be accepted per the IDLE rules. Memory is never written on an erroring transfer.
- Read-after-write to the same word in back-to-back transfers returns the new data: the write commits on the edge that starts the read's data phase.
- hrdata is 0 in every cycle except a read LAST cycle.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles after the address phase. Back-to-back transfers sustain one transfer every WAIT_STATES+1 cycles.
- ERROR occupies exactly 2 data-phase cycles.
- All outputs are driven from registers or from the mem array through addr_q. There is no combinational path from slave_in to slave_out.
- hreset asserted mid-transfer (WAIT, LAST, ERR1 or ERR2): the transfer is abandoned, any pending write is not committed, and outputs take reset values on the next edge.
- hsel may drop during a data phase. The pending transfer still completes.

## Configuration
- `AHB_SLV_ERR_EN` defined: error detection as above; hresp can be 1.
- `AHB_SLV_ERR_EN` undefined:
  - the error path, ERR1 and ERR2 are compiled out;
  - hresp is tied to 0;
  - hsize>2 is treated as a word access;
  - low address bits below the access size are ignored;
  - the word index wraps modulo DEPTH.

## Test plan
- Reset, WAIT_STATES=0:
  - write NONSEQ haddr=0x10, hwdata=0xDEADBEEF, then read 0x10 → read data phase hreadyout=1, hrdata=0xDEADBEEF, hresp=0.
- Byte write:
  - stimulus: hsize=0, haddr=0x13, hwdata=0xAA000000 over word 0x11223344;
  - response: read 0x10 returns 0xAA223344.
- WAIT_STATES=2, back-to-back write then read of the same address:
  - each data phase shows hreadyout 0,0,1;
  - the read returns the just-written value;
  - no address is sampled while hreadyout=0.
- `AHB_SLV_ERR_EN`, word read at haddr=0x2 → hreadyout/hresp = 0/1 then 1/1; a following valid read is accepted in ERR2 and completes OKAY.
- `AHB_SLV_ERR_EN`, DEPTH=256, write haddr=0x400 → ERROR, and a later read of 0x000 shows the memory unchanged.
- hreset pulsed during a write's WAIT cycle → outputs return to 1/0/0 next cycle, and the target word is unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave port serving a word-addressed register memory with optional wait states.
// Define AHB_SLV_ERR_EN to enable ERROR responses for bad size, misalignment and out-of-range accesses.
package ahb_sram_slave_pkg;
  typedef struct packed {
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [3:0]  hprot;
    logic        hmastlock;
  } mas_send_type;

  typedef struct packed {
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;
  } slv_send_type;
endpackage

module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned REGION_W    = 16
) (
  input  logic         hclk,
  input  logic         hreset,
  input  logic         hsel,
  input  mas_send_type slave_in,
  output slv_send_type slave_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | no data phase pending, address phase open
  // WAIT  | OKAY data phase, hreadyout held low
  // LAST  | final OKAY cycle: read data valid, write commits at its end
  // ERR1  | first ERROR cycle, hreadyout low
  // ERR2  | second ERROR cycle, address phase open
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST
`ifdef AHB_SLV_ERR_EN
    ,
    S_ERR1,
    S_ERR2
`endif
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_hreadyout;
  logic [AW-1:0] r_addr;
  logic [1:0]  r_lane;
  logic [2:0]  r_size;
  logic        r_write;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_rdata;
  logic        w_hresp;
  logic        w_unused;

  assign w_accept = hsel & slave_in.htrans[1] & r_hreadyout;
  assign w_unused = ^{slave_in};

`ifdef AHB_SLV_ERR_EN
  logic w_err;
  logic w_oor;
  logic r_hresp;

  if (REGION_W > AW + 2) begin : g_oor
    assign w_oor = |slave_in.haddr[REGION_W-1:AW+2];
  end else begin : g_no_oor
    assign w_oor = 1'b0;
  end

  assign w_err = (slave_in.hsize > 3'd2)
               | ((slave_in.hsize == 3'd1) & slave_in.haddr[0])
               | ((slave_in.hsize == 3'd2) & (slave_in.haddr[1:0] != 2'b00))
               | w_oor;

  // hresp is high exactly while the FSM sits in ERR1 or ERR2
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_hresp <= 1'b0;
    end else begin
      r_hresp <= (r_state == S_ERR1) | (w_accept & w_err);
    end
  end

  assign w_hresp = r_hresp;
`else
  logic [31:0] w_unused_region;
  assign w_unused_region = REGION_W;
  assign w_hresp         = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_hreadyout <= 1'b1;
      r_addr      <= '0;
      r_lane      <= 2'd0;
      r_size      <= 3'd0;
      r_write     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state     <= S_LAST;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef AHB_SLV_ERR_EN
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
        end
`endif
        default: begin
          if (w_accept) begin
            r_addr  <= slave_in.haddr[AW+1:2];
            r_lane  <= slave_in.haddr[1:0];
            r_size  <= slave_in.hsize;
            r_write <= slave_in.hwrite;
`ifdef AHB_SLV_ERR_EN
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
            end else
`endif
            if (WAIT_STATES != 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= 4'(WAIT_STATES);
              r_hreadyout <= 1'b0;
            end else begin
              r_state     <= S_LAST;
              r_hreadyout <= 1'b1;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end
        end
      endcase
    end
  end

  // Halfword lanes use only haddr[1]; anything wider than a halfword writes the whole word.
  always_comb begin
    w_be = 4'hF;
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_lane;
      3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'hF;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset && (r_state == S_LAST) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_addr][8*b +: 8] <= slave_in.hwdata[8*b +: 8];
        end
      end
    end
  end

  assign w_rdata = ((r_state == S_LAST) && !r_write) ? r_mem[r_addr] : 32'h0;

  assign slave_out.hreadyout = r_hreadyout;
  assign slave_out.hrdata    = w_rdata;
  assign slave_out.hresp     = w_hresp;

endmodule
